// File: rtl/data_mem_dma_if.sv
// Command/status and data_mem port bundle for the block-copy/fill engine.
// master = engine side, slave = command source plus memory side.
interface data_mem_dma_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] len;
  logic [DATA_W-1:0] fill_val;
  logic              abort;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;

  modport master (
    input  start, mode, src_addr, dst_addr, len, fill_val, abort, mem_rdata,
    output mem_addr, mem_wdata, mem_we, busy, done, checksum
  );

  modport slave (
    output start, mode, src_addr, dst_addr, len, fill_val, abort, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, busy, done, checksum
  );
endinterface

// File: rtl/data_mem_dma.sv
// Copy/fill engine on data_mem: copy = 2*len busy cycles, fill = len, then one done cycle.
// No backpressure: owns the memory port while busy; abort cancels after the current write.
module data_mem_dma #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input logic           clk,
  input logic           reset,
  data_mem_dma_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_src_ptr;
  logic [ADDR_W-1:0] r_dst_ptr;
  logic [ADDR_W-1:0] r_count;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_checksum;
  logic [DATA_W-1:0] r_fill_val;
  logic              r_mode;

  logic [DATA_W-1:0] w_wdata;

  // Port outputs decode registered state only, so no input reaches them combinationally.
  assign w_wdata       = (r_state == S_WRITE && r_mode) ? r_fill_val : r_data;
  assign bus.mem_wdata = w_wdata;
  assign bus.mem_addr  = (r_state == S_READ) ? r_src_ptr : r_dst_ptr;
  assign bus.mem_we    = (r_state == S_WRITE);
  assign bus.busy      = (r_state == S_READ) || (r_state == S_WRITE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.checksum  = r_checksum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_src_ptr  <= '0;
      r_dst_ptr  <= '0;
      r_count    <= '0;
      r_data     <= '0;
      r_checksum <= '0;
      r_fill_val <= '0;
      r_mode     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_src_ptr  <= bus.src_addr;
            r_dst_ptr  <= bus.dst_addr;
            r_count    <= bus.len;
            r_mode     <= bus.mode;
            r_fill_val <= bus.fill_val;
            r_checksum <= '0;
            if (bus.len == '0)
              r_state <= S_DONE;
            else if (bus.mode)
              r_state <= S_WRITE;
            else
              r_state <= S_READ;
          end
        end
        S_READ: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
          end else begin
            r_data    <= bus.mem_rdata;
            r_src_ptr <= r_src_ptr + 1'b1;
            r_state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          // The write in this cycle commits even when aborted, so its bookkeeping does too.
          r_dst_ptr  <= r_dst_ptr + 1'b1;
          r_count    <= r_count - 1'b1;
          r_checksum <= r_checksum + w_wdata;
          if (bus.abort)
            r_state <= S_IDLE;
          else if (r_count == ADDR_W'(1))
            r_state <= S_DONE;
          else if (r_mode)
            r_state <= S_WRITE;
          else
            r_state <= S_READ;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_dma.sv
// Directed bench for data_mem_dma with a behavioural data_mem beside it.
// Covers copy, fill, address wrap with overlap, len=0, abort and mid-transfer reset.
module tb_data_mem_dma;

  localparam int AW = 8;
  localparam int DW = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  data_mem_dma_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  data_mem_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory with a side port for preloading.
  logic [15:0] mem [256];
  logic        tb_we    = 1'b0;
  logic [7:0]  tb_waddr = '0;
  logic [15:0] tb_wdata = '0;

  always @(posedge clk) begin
    if (bus.mem_we)
      mem[bus.mem_addr] <= bus.mem_wdata;
    else if (tb_we)
      mem[tb_waddr] <= tb_wdata;
  end

  assign bus.mem_rdata = mem[bus.mem_addr];

  int n_vec    = 0;
  int n_miss   = 0;
  int busy_cnt = 0;
  int we_cnt   = 0;
  int done_cnt = 0;
  logic [7:0] rd_q [$];
  logic [7:0] wr_q [$];

  always @(negedge clk) begin
    if (bus.busy) busy_cnt++;
    if (bus.done) done_cnt++;
    if (bus.mem_we) begin
      we_cnt++;
      wr_q.push_back(bus.mem_addr);
    end else if (bus.busy) begin
      rd_q.push_back(bus.mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    tb_we    = 1'b1;
    tb_waddr = a;
    tb_wdata = d;
    @(negedge clk);
    tb_we    = 1'b0;
  endtask

  // Presents a command for one sampling edge; returns at the negedge after it.
  task automatic start_cmd(input logic m, input logic [7:0] s, input logic [7:0] d,
                           input logic [7:0] l, input logic [15:0] fv);
    @(negedge clk);
    bus.mode     = m;
    bus.src_addr = s;
    bus.dst_addr = d;
    bus.len      = l;
    bus.fill_val = fv;
    bus.start    = 1'b1;
    busy_cnt     = 0;
    we_cnt       = 0;
    done_cnt     = 0;
    rd_q.delete();
    wr_q.delete();
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else @(negedge clk);
    end
    chk(tag, 32'(seen), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.mode     = 1'b0;
    bus.src_addr = '0;
    bus.dst_addr = '0;
    bus.len      = '0;
    bus.fill_val = '0;
    bus.abort    = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_addr",  32'(bus.mem_addr),  32'h0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'h0);
    chk("rst_we",    32'(bus.mem_we),    32'h0);
    chk("rst_busy",  32'(bus.busy),      32'h0);
    chk("rst_done",  32'(bus.done),      32'h0);
    chk("rst_csum",  32'(bus.checksum),  32'h0);
    reset = 1'b0;

    poke(8'h10, 16'h1111);
    poke(8'h11, 16'h2222);
    poke(8'h12, 16'h3333);
    poke(8'h13, 16'h4444);
    poke(8'h44, 16'hFFFF);
    poke(8'h90, 16'h5555);

    // Copy 4 words 0x10 -> 0x80
    start_cmd(1'b0, 8'h10, 8'h80, 8'd4, 16'h0);
    wait_done("copy_done_seen");
    chk("copy_m80",  32'(mem[8'h80]), 32'h1111);
    chk("copy_m81",  32'(mem[8'h81]), 32'h2222);
    chk("copy_m82",  32'(mem[8'h82]), 32'h3333);
    chk("copy_m83",  32'(mem[8'h83]), 32'h4444);
    chk("copy_busy", 32'(busy_cnt),   32'd8);
    chk("copy_done", 32'(done_cnt),   32'd1);
    chk("copy_we",   32'(we_cnt),     32'd4);
    chk("copy_csum", 32'(bus.checksum), 32'hAAAA);
    chk("copy_idle", 32'({bus.busy, bus.done, bus.mem_we}), 32'h0);

    // Fill 3 words at 0x20 with 0xBEEF
    start_cmd(1'b1, 8'h00, 8'h20, 8'd3, 16'hBEEF);
    wait_done("fill_done_seen");
    chk("fill_m20",  32'(mem[8'h20]), 32'hBEEF);
    chk("fill_m21",  32'(mem[8'h21]), 32'hBEEF);
    chk("fill_m22",  32'(mem[8'h22]), 32'hBEEF);
    chk("fill_we",   32'(we_cnt),     32'd3);
    chk("fill_busy", 32'(busy_cnt),   32'd3);
    chk("fill_done", 32'(done_cnt),   32'd1);
    chk("fill_csum", 32'(bus.checksum), 32'h3CCD);

    // Wrapping, overlapping copy FE -> 00
    poke(8'hFE, 16'h0101);
    poke(8'hFF, 16'h0202);
    poke(8'h00, 16'h0303);
    poke(8'h01, 16'h0404);
    start_cmd(1'b0, 8'hFE, 8'h00, 8'd4, 16'h0);
    wait_done("wrap_done_seen");
    chk("wrap_nrd", 32'(rd_q.size()), 32'd4);
    chk("wrap_nwr", 32'(wr_q.size()), 32'd4);
    if (rd_q.size() == 4 && wr_q.size() == 4) begin
      chk("wrap_rd", {rd_q[0], rd_q[1], rd_q[2], rd_q[3]}, 32'hFEFF0001);
      chk("wrap_wr", {wr_q[0], wr_q[1], wr_q[2], wr_q[3]}, 32'h00010203);
    end
    chk("wrap_m00",  32'(mem[8'h00]), 32'h0101);
    chk("wrap_m01",  32'(mem[8'h01]), 32'h0202);
    chk("wrap_m02",  32'(mem[8'h02]), 32'h0101);
    chk("wrap_m03",  32'(mem[8'h03]), 32'h0202);
    chk("wrap_mFE",  32'(mem[8'hFE]), 32'h0101);
    chk("wrap_csum", 32'(bus.checksum), 32'h0606);

    // len = 0: done next cycle, nothing written
    start_cmd(1'b1, 8'h00, 8'h30, 8'd0, 16'h7777);
    chk("len0_done_next", 32'(bus.done), 32'd1);
    chk("len0_busy_next", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    chk("len0_busy", 32'(busy_cnt),     32'd0);
    chk("len0_we",   32'(we_cnt),       32'd0);
    chk("len0_done", 32'(done_cnt),     32'd1);
    chk("len0_csum", 32'(bus.checksum), 32'h0);

    // Abort a 10-word fill during its 4th write; a start mid-transfer is ignored
    start_cmd(1'b1, 8'h00, 8'h40, 8'd10, 16'h1234);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.mode     = 1'b0;
    bus.dst_addr = 8'h90;
    bus.len      = 8'd1;
    @(negedge clk);
    bus.start    = 1'b0;
    @(negedge clk);
    bus.abort    = 1'b1;
    @(negedge clk);
    bus.abort    = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_we",   32'(we_cnt),   32'd4);
    chk("abort_busy", 32'(busy_cnt), 32'd4);
    chk("abort_done", 32'(done_cnt), 32'd0);
    chk("abort_idle", 32'({bus.busy, bus.done}), 32'h0);
    chk("abort_m43",  32'(mem[8'h43]), 32'h1234);
    chk("abort_m44",  32'(mem[8'h44]), 32'hFFFF);
    chk("abort_m90",  32'(mem[8'h90]), 32'h5555);

    // Reset during the second READ of a 5-word copy
    start_cmd(1'b0, 8'h10, 8'hA0, 8'd5, 16'h0);
    repeat (2) @(negedge clk);
    chk("mrst_in_read", 32'({bus.busy, bus.mem_we}), 32'h2);
    reset = 1'b1;
    #1;
    chk("mrst_addr",  32'(bus.mem_addr),  32'h0);
    chk("mrst_wdata", 32'(bus.mem_wdata), 32'h0);
    chk("mrst_we",    32'(bus.mem_we),    32'h0);
    chk("mrst_busy",  32'(bus.busy),      32'h0);
    chk("mrst_done",  32'(bus.done),      32'h0);
    chk("mrst_csum",  32'(bus.checksum),  32'h0);
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_mA0",   32'(mem[8'hA0]),    32'h1111);
    start_cmd(1'b0, 8'h10, 8'hB0, 8'd2, 16'h0);
    wait_done("post_rst_done_seen");
    chk("post_rst_mB0",  32'(mem[8'hB0]),   32'h1111);
    chk("post_rst_mB1",  32'(mem[8'hB1]),   32'h2222);
    chk("post_rst_busy", 32'(busy_cnt),     32'd4);
    chk("post_rst_csum", 32'(bus.checksum), 32'h3333);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
